dvp_capture_ext: RTL
====================

Name: dvp_capture_ext

Overview:
Parametrised successor to the OV5640 DVP capture front end. Samples the camera's PCLK-domain DVP bus (Vsync, Href, Data) and assembles 1- or 2-byte pixels. Generates aligned pixel-valid, line and frame strobes and X/Y coordinates for the downstream frame buffer / image processing pipe. Also provides a programmable frame-skip warm-up and per-frame geometry checking.

Parameters:
DATA_W, 8, DVP data bus width in bits.
BYTES_PER_PIX, 2, bytes per pixel: 1 (RAW/Y8) or 2 (RGB565); other values illegal.
MSB_FIRST, 1, 1: first byte of a pixel lands in DataPixel upper half; 0: lower half.
VS_POL, 1, active level of Vsync (1 = high pulse marks frame start).
SKIP_FRAMES, 10, frames discarded after reset before ImageState rises (0 = none).
ADDR_W, 12, width of Xaddr/Yaddr.
H_ACTIVE, 640, expected pixels per line, used for error check.
V_ACTIVE, 480, expected lines per frame, used for error check.

Ports:
PCLK  in  1  camera pixel clock; all logic on rising edge.
Rst_n  in  1  asynchronous active-low reset.
Vsync  in  1  DVP frame sync, polarity per VS_POL.
Href  in  1  DVP line valid, active high.
Data  in  DATA_W  DVP data byte.
ImageState  out  1  1 once SKIP_FRAMES frames have passed; outputs valid.
DataValid  out  1  one-cycle strobe: DataPixel/Xaddr/Yaddr valid.
DataPixel  out  DATA_W*BYTES_PER_PIX  assembled pixel.
DataHs  out  1  Href delayed to align with DataValid, gated by ImageState.
DataVs  out  1  Vsync (normalised active-high) delayed/aligned, gated by ImageState.
Xaddr  out  ADDR_W  pixel index within line of current DataPixel.
Yaddr  out  ADDR_W  line index within frame of current DataPixel.
FrameErr  out  1  one-cycle pulse: completed frame geometry mismatch.

Behaviour:
- Reset (Rst_n=0, async): all outputs 0, skip counter 0, byte phase 0, state WARMUP (READY if SKIP_FRAMES=0). Reset mid-frame discards the partial frame; the first frame-start edge after release is counted.
- Input stage: Vsync/Href/Data registered once on PCLK. Frame start = active edge of registered Vsync (inactive->active).
- FSM WARMUP: count frame starts; on the SKIP_FRAMES-th, go READY and set ImageState=1 at that edge. READY: stays until reset. ImageState never falls otherwise.
- Pixel assembly: byte phase counts 0..BYTES_PER_PIX-1 while registered Href=1; phase clears on Href low and on frame start. When the completing byte is sampled on edge k, DataValid=1 after edge k+1 for exactly one cycle. Latency from Data pin to DataPixel = 2 PCLK. DataValid only when ImageState=1.
- BYTES_PER_PIX=1: every Href-high byte is a pixel.
- Xaddr: value for each pixel is its 0-based index within the line; counter clears on Href falling edge. Yaddr: line index; increments on Href falling when ≥1 pixel was produced in that line; clears on frame start. Both saturate at 2^ADDR_W-1 (no wrap).
- Odd trailing byte (Href falls with phase≠0): byte dropped, no DataValid, line flagged bad.
- Frame start while Href high (mid-line): line aborted, phase/Xaddr cleared, no partial pixel output, frame flagged bad.
- FrameErr: at each frame start in READY, pulse one cycle if the preceding frame had Yaddr line count ≠ V_ACTIVE, any line ≠ H_ACTIVE pixels, or a bad line/frame flag. No pulse at the first frame start after entering READY (no complete frame yet).
- DataHs/DataVs: same 2-cycle latency as DataPixel, forced 0 while ImageState=0.

Optional Feature:
DVP_FRAME_STATS_EN: adds outputs FrameWidth[ADDR_W] and FrameHeight[ADDR_W], holding the pixel count of the last line and the line count of the last completed frame. Both update at frame start alongside FrameErr and reset to 0. Without the macro these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset hold 805 ns, then 15 frames of 16x12 RGB565 (32 Href bytes/line, descending data), SKIP_FRAMES=10 -> ImageState rises at the 10th Vsync; 12 lines x 16 DataValid per frame afterwards, none before.
- Bytes 0xFF,0xFE with MSB_FIRST=1 -> DataPixel=0xFFFE, Xaddr=0, 2 cycles after 0xFE sampled; MSB_FIRST=0 -> 0xFEFF.
- H_ACTIVE=16, V_ACTIVE=12, clean frames -> FrameErr never pulses; one line shortened to 15 pixels -> single FrameErr pulse at next Vsync.
- Line with 31 bytes -> 15 pixels, last byte dropped, FrameErr at next frame start.
- Vsync asserted mid-line at pixel 5 -> no further DataValid for that line; Xaddr/Yaddr restart at 0 in the new frame.
- Rst_n pulsed low during frame 12 -> all outputs 0 immediately; ImageState returns only after 10 more frame starts.

Source files
------------

// File: rtl/dvp_capture_ext.sv
// dvp_capture_ext: DVP camera capture front end (PCLK domain).
//   Registers Vsync/Href/Data once, assembles BYTES_PER_PIX-byte pixels,
//   emits pixel-valid strobes, aligned line/frame syncs and X/Y coordinates.
//   Discards SKIP_FRAMES frames after reset (warm-up) and checks each
//   completed frame against H_ACTIVE x V_ACTIVE.
// Ports:
//   PCLK, Rst_n        clock (rising edge), async active-low reset
//   Vsync, Href, Data  DVP input bus (Vsync polarity set by VS_POL)
//   ImageState         warm-up done, outputs meaningful
//   DataValid          one-cycle strobe, DataPixel/Xaddr/Yaddr valid
//   DataPixel          assembled pixel (first byte high when MSB_FIRST=1)
//   DataHs, DataVs     Href / normalised Vsync, aligned to DataPixel, gated
//   Xaddr, Yaddr       pixel / line index of current DataPixel (saturating)
//   FrameErr           one-cycle pulse at frame start: last frame malformed
// Optional: define DVP_FRAME_STATS_EN to add FrameWidth/FrameHeight
//   (last line pixel count / last frame line count, updated at frame start).
module dvp_capture_ext #(
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int MSB_FIRST     = 1,
  parameter int VS_POL        = 1,
  parameter int SKIP_FRAMES   = 10,
  parameter int ADDR_W        = 12,
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480
) (
  input  logic                            PCLK,
  input  logic                            Rst_n,
  input  logic                            Vsync,
  input  logic                            Href,
  input  logic [DATA_W-1:0]               Data,
  output logic                            ImageState,
  output logic                            DataValid,
  output logic [DATA_W*BYTES_PER_PIX-1:0] DataPixel,
  output logic                            DataHs,
  output logic                            DataVs,
  output logic [ADDR_W-1:0]               Xaddr,
  output logic [ADDR_W-1:0]               Yaddr,
  output logic                            FrameErr
`ifdef DVP_FRAME_STATS_EN
  ,
  output logic [ADDR_W-1:0]               FrameWidth,
  output logic [ADDR_W-1:0]               FrameHeight
`endif
);

  localparam int PH_W = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
  localparam int SK_W = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(BYTES_PER_PIX - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  typedef enum logic {WARMUP, READY} state_t;
  localparam state_t RST_ST = (SKIP_FRAMES == 0) ? READY : WARMUP;

  state_t state_q, state_d;

  logic              vs_r, vs_q, hr_r, hr_q;
  logic [DATA_W-1:0] d_r;
  logic [SK_W-1:0]   skip_q;
  logic [PH_W-1:0]   phase;
  logic [ADDR_W-1:0] xcnt, ycnt;
  logic              abort, bad, seen;
  logic [BYTES_PER_PIX-1:0][DATA_W-1:0] byte_q, bytes_d, pix_d;
`ifdef DVP_FRAME_STATS_EN
  logic [ADDR_W-1:0] last_w;
`endif

  logic fs, line_end, ready;
  assign fs         = vs_r & ~vs_q;
  assign line_end   = hr_q & ~hr_r;
  assign ready      = (state_q == READY);
  assign ImageState = ready;

  // input stage; Vsync normalised to active-high here
  always_ff @(posedge PCLK or negedge Rst_n) begin
    if (!Rst_n) begin
      vs_r <= 1'b0; vs_q <= 1'b0; hr_r <= 1'b0; hr_q <= 1'b0; d_r <= '0;
    end else begin
      vs_r <= (Vsync == VS_POL[0]);
      vs_q <= vs_r;
      hr_r <= Href;
      hr_q <= hr_r;
      d_r  <= Data;
    end
  end

  always_ff @(posedge PCLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= RST_ST;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == WARMUP && fs) skip_q <= skip_q + SK_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WARMUP:  if (fs && skip_q == SK_W'(SKIP_FRAMES - 1)) state_d = READY;
      default: state_d = READY;
    endcase
  end

  // incoming byte merged into the held bytes, then placed by byte order
  always_comb begin
    bytes_d        = byte_q;
    bytes_d[phase] = d_r;
    pix_d          = '0;
    for (int i = 0; i < BYTES_PER_PIX; i++) begin
      if (MSB_FIRST != 0) pix_d[BYTES_PER_PIX-1-i] = bytes_d[i];
      else                pix_d[i]                 = bytes_d[i];
    end
  end

  always_ff @(posedge PCLK or negedge Rst_n) begin
    if (!Rst_n) begin
      phase <= '0; xcnt <= '0; ycnt <= '0; byte_q <= '0;
      abort <= 1'b0; bad <= 1'b0; seen <= 1'b0;
      DataValid <= 1'b0; DataPixel <= '0; Xaddr <= '0; Yaddr <= '0;
      DataHs <= 1'b0; DataVs <= 1'b0; FrameErr <= 1'b0;
`ifdef DVP_FRAME_STATS_EN
      last_w <= '0; FrameWidth <= '0; FrameHeight <= '0;
`endif
    end else begin
      DataValid <= 1'b0;
      FrameErr  <= 1'b0;
      DataHs    <= hr_r & ready;
      DataVs    <= vs_r & ready;
      if (fs) begin
        // frame start while Href high: rest of that line is ignored
        FrameErr <= seen & ((ycnt != ADDR_W'(V_ACTIVE)) | bad | hr_r);
        seen     <= seen | (state_d == READY);
        abort    <= hr_r;
        bad      <= 1'b0;
        phase    <= '0;
        xcnt     <= '0;
        ycnt     <= '0;
`ifdef DVP_FRAME_STATS_EN
        FrameWidth  <= last_w;
        FrameHeight <= ycnt;
`endif
      end else if (hr_r && !abort) begin
        byte_q <= bytes_d;
        if (phase == PH_LAST) begin
          phase <= '0;
          if (ready) begin
            DataValid <= 1'b1;
            DataPixel <= pix_d;
            Xaddr     <= xcnt;
            Yaddr     <= ycnt;
          end
          if (xcnt != ADDR_MAX) xcnt <= xcnt + ADDR_W'(1);
        end else begin
          phase <= phase + PH_W'(1);
        end
      end else begin
        phase <= '0;
        if (line_end) begin
          if (abort) begin
            abort <= 1'b0;
          end else begin
            // a nonzero phase here means a trailing odd byte was dropped
            if (phase != '0 || xcnt != ADDR_W'(H_ACTIVE)) bad <= 1'b1;
            if (xcnt != '0 && ycnt != ADDR_MAX) ycnt <= ycnt + ADDR_W'(1);
`ifdef DVP_FRAME_STATS_EN
            last_w <= xcnt;
`endif
          end
          xcnt <= '0;
        end
      end
    end
  end

endmodule
